link_lock_monitor: RTL and testbench
====================================

Name: link_lock_monitor

Overview:
- Synthesizable, multi-channel successor to the loopback bench's lock/PRBS tracking.
- Per lane, it timestamps first bit lock, first frame lock and first PRBS match, and detects PRBS stability over a programmable window.
- It also counts match drops, classifies each lane into a result code, and issues a periodic report strobe.
- Sits beside the FEC/GTH loopback core, in the same clock domain as the lane status signals; results are read by the debug register bank.

Parameters:
- NCH, 4, number of monitored lanes (1..16)
- TS_W, 32, timestamp / counter width in clk cycles
- STABLE_CYCLES, 100000, consecutive matching cycles required to declare a lane stable (>=1)
- REPORT_CYCLES, 200000, period of report_pulse in clk cycles (>=2)
- DROP_W, 16, width of the per-lane match-drop counter

Ports:
- clk  in  1  monitor clock
- rst  in  1  synchronous, active-high reset
- bit_locked  in  NCH  per-lane bit lock (level)
- frame_locked  in  NCH  per-lane frame lock (level)
- prbs_meas_ok  in  NCH  per-lane PRBS measurement valid
- prbs_match  in  NCH  per-lane PRBS error vector == 0
- clear  in  1  synchronous clear of all sticky statistics
- rd_ch  in  clog2(NCH)  lane select for readback
- rd_sel  in  3  field select: 0 ts_bit, 1 ts_frame, 2 ts_match, 3 drop_cnt, 4 run_cnt, 5 status, 6 now, 7 zero
- rd_data  out  TS_W  selected field, zero-extended, registered
- stable  out  NCH  sticky per-lane stable flag
- status  out  3*NCH  per-lane result code
- all_stable  out  1  AND of stable
- report_pulse  out  1  one-cycle strobe every REPORT_CYCLES

Behaviour:
- Reset: all outputs 0. Timestamp counter `now` = 1. All per-lane registers = 0.
- `now` increments every cycle and saturates at all-ones; it never wraps. `clear` does not affect `now`.
- Timestamp value 0 means "never happened".
- First-event capture, per lane, evaluated independently:
  - ts_bit <= now on the first cycle bit_locked=1 while ts_bit==0.
  - ts_frame and ts_match behave the same, triggered by frame_locked and (prbs_meas_ok & prbs_match) respectively.
  - After capture the value is held until rst or clear.
- Run counter, per lane:
  - Increments (saturating at STABLE_CYCLES) on each cycle with meas_ok & match.
  - Forced to 0 on any other cycle.
  - stable sets on the cycle after run_cnt reaches STABLE_CYCLES; it is sticky even if the match later drops.
- Drop counter: increments, saturating at 2^DROP_W-1, when the previous cycle matched, the current cycle does not, and ts_match != 0.
- Status code (combinational from registers, registered out):
  - 4 = stable
  - 3 = ts_match != 0
  - 2 = ts_frame != 0
  - 1 = ts_bit != 0
  - 0 = none
  - Highest applicable code wins.
- Report timer:
  - Counts 0..REPORT_CYCLES-1 and pulses report_pulse on terminal count.
  - Restarts at 0 on rst or clear.
- Readback: rd_data is valid one cycle after rd_ch/rd_sel. rd_ch >= NCH returns 0.
- Simultaneous events:
  - clear in the same cycle as a capture or drop: clear wins and the event is discarded.
  - A lane asserting all three inputs in one cycle gets identical timestamps in all three fields.
- Reset mid-operation: rst in any cycle restores the full reset state on the next edge, with no partial state retained.

Optional Feature:
- Macro LINK_LOCK_MONITOR_TIMEOUT_EN adds parameter TIMEOUT_CYCLES (default 2000000) and output timeout [NCH].
- A lane's timeout bit sets (sticky) when now >= TIMEOUT_CYCLES and stable is still 0. It clears on rst or clear.
- While a lane's timeout bit is set, that lane's status reads 7.
- Without the macro: no port, no logic, and status never takes the value 7.

Decomposition:
- Package link_lock_monitor_pkg holds:
  - status code constants (ST_NONE=0, ST_BIT=1, ST_FRAME=2, ST_MATCH=3, ST_STABLE=4, ST_TIMEOUT=7)
  - rd_sel field constants
  - a saturating-increment function
- Sub-module llm_lane holds one lane's capture, run, drop and status logic, instantiated NCH times.
- The top holds `now`, the report timer and the readback mux.

Test Plan:
- NCH=2, STABLE_CYCLES=16, REPORT_CYCLES=100. Lane0 bit_locked at cycle 10, frame at 20, match from 30 continuously -> ts_bit=11, ts_frame=21, ts_match=31; stable rises at cycle 47; status=4; lane1 status=0.
- Lane0 match held for 15 cycles, one miss, then 16 more -> stable stays 0 until the second run completes; drop_cnt=1.
- Match toggles every cycle for 40 cycles after first match -> drop_cnt=20, stable=0, status=3.
- clear asserted on the same cycle as lane1's first bit_locked -> ts_bit stays 0; on the next cycle it captures now; report_pulse is next seen exactly 100 cycles after clear.
- rst pulsed mid-run with lane0 stable -> all outputs 0 on the next cycle; now restarts at 1; rd_sel=6 reads 2 one cycle after the read request.
- With LINK_LOCK_MONITOR_TIMEOUT_EN and TIMEOUT_CYCLES=50: lane never matches -> timeout[0]=1 from cycle 50 and status=7; a lane that is stable before cycle 50 is unaffected.

Source files
------------

// File: rtl/link_lock_monitor_pkg.sv
// Shared status codes, readback field selects and saturating increment for link_lock_monitor.
// Latency: none (constants and a pure function only).
// Backpressure: none.
package link_lock_monitor_pkg;

    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_BIT     = 3'd1;
    localparam logic [2:0] ST_FRAME   = 3'd2;
    localparam logic [2:0] ST_MATCH   = 3'd3;
    localparam logic [2:0] ST_STABLE  = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd7;

    localparam logic [2:0] RD_TS_BIT   = 3'd0;
    localparam logic [2:0] RD_TS_FRAME = 3'd1;
    localparam logic [2:0] RD_TS_MATCH = 3'd2;
    localparam logic [2:0] RD_DROP_CNT = 3'd3;
    localparam logic [2:0] RD_RUN_CNT  = 3'd4;
    localparam logic [2:0] RD_STATUS   = 3'd5;
    localparam logic [2:0] RD_NOW      = 3'd6;
    localparam logic [2:0] RD_ZERO     = 3'd7;

    // Callers zero-extend into 32 bits and cast the result back to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val >= max) ? max : val + 32'd1;
    endfunction

endpackage

// File: rtl/llm_lane.sv
// One lane: first-event timestamps, match run/drop counters, sticky stable flag and status code.
// Latency: all outputs registered, status one cycle behind the registers it summarises.
// Backpressure: none; observes level inputs every cycle.
module llm_lane
    import link_lock_monitor_pkg::*;
#(
    parameter int TS_W          = 32,
    parameter int STABLE_CYCLES = 100000,
    parameter int DROP_W        = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [TS_W-1:0]   now,
    input  logic              bit_locked,
    input  logic              frame_locked,
    input  logic              prbs_meas_ok,
    input  logic              prbs_match,
`ifdef LINK_LOCK_MONITOR_TIMEOUT_EN
    input  logic              timeout_hit,
    output logic              timeout,
`endif
    output logic [TS_W-1:0]   ts_bit,
    output logic [TS_W-1:0]   ts_frame,
    output logic [TS_W-1:0]   ts_match,
    output logic [TS_W-1:0]   run_cnt,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              stable,
    output logic [2:0]        status
);

    logic       match_now;
    logic       prev_match;
    logic [2:0] code;

    assign match_now = prbs_meas_ok & prbs_match;

    always_comb begin
        code = ST_NONE;
        if (stable)                 code = ST_STABLE;
        else if (ts_match != '0)    code = ST_MATCH;
        else if (ts_frame != '0)    code = ST_FRAME;
        else if (ts_bit != '0)      code = ST_BIT;
`ifdef LINK_LOCK_MONITOR_TIMEOUT_EN
        if (timeout)                code = ST_TIMEOUT;
`endif
    end

    // clear shares the reset path so any same-cycle capture or drop is discarded.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ts_bit     <= '0;
            ts_frame   <= '0;
            ts_match   <= '0;
            run_cnt    <= '0;
            drop_cnt   <= '0;
            stable     <= 1'b0;
            status     <= ST_NONE;
            prev_match <= 1'b0;
`ifdef LINK_LOCK_MONITOR_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
        end else begin
            if (ts_bit == '0 && bit_locked)     ts_bit   <= now;
            if (ts_frame == '0 && frame_locked) ts_frame <= now;
            if (ts_match == '0 && match_now)    ts_match <= now;
            run_cnt <= match_now ? TS_W'(sat_inc(32'(run_cnt), 32'(STABLE_CYCLES))) : '0;
            stable  <= stable | (run_cnt == TS_W'(STABLE_CYCLES));
            if (prev_match && !match_now && ts_match != '0)
                drop_cnt <= DROP_W'(sat_inc(32'(drop_cnt), 32'({DROP_W{1'b1}})));
            prev_match <= match_now;
            status     <= code;
`ifdef LINK_LOCK_MONITOR_TIMEOUT_EN
            timeout    <= timeout | (timeout_hit & ~stable);
`endif
        end
    end

endmodule

// File: rtl/link_lock_monitor.sv
// Multi-lane lock/PRBS monitor with timestamp counter, report strobe and registered readback.
// Latency: rd_data one cycle after rd_ch/rd_sel; no backpressure, all inputs sampled every cycle.
// Optional lane timeout output enabled by LINK_LOCK_MONITOR_TIMEOUT_EN.
module link_lock_monitor
    import link_lock_monitor_pkg::*;
#(
    parameter int NCH           = 4,
    parameter int TS_W          = 32,
    parameter int STABLE_CYCLES = 100000,
    parameter int REPORT_CYCLES = 200000,
    parameter int DROP_W        = 16,
`ifdef LINK_LOCK_MONITOR_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 2000000,
`endif
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int RPT_W = $clog2(REPORT_CYCLES)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    bit_locked,
    input  logic [NCH-1:0]    frame_locked,
    input  logic [NCH-1:0]    prbs_meas_ok,
    input  logic [NCH-1:0]    prbs_match,
    input  logic              clear,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [TS_W-1:0]   rd_data,
    output logic [NCH-1:0]    stable,
    output logic [3*NCH-1:0]  status,
`ifdef LINK_LOCK_MONITOR_TIMEOUT_EN
    output logic [NCH-1:0]    timeout,
`endif
    output logic              all_stable,
    output logic              report_pulse
);

    logic [TS_W-1:0]   now;
    logic [RPT_W-1:0]  rpt_cnt;
    logic [TS_W-1:0]   rd_mux;
    logic [TS_W-1:0]   ts_bit_a   [NCH];
    logic [TS_W-1:0]   ts_frame_a [NCH];
    logic [TS_W-1:0]   ts_match_a [NCH];
    logic [TS_W-1:0]   run_cnt_a  [NCH];
    logic [DROP_W-1:0] drop_cnt_a [NCH];
    logic [2:0]        status_a   [NCH];

`ifdef LINK_LOCK_MONITOR_TIMEOUT_EN
    logic timeout_hit;
    assign timeout_hit = (now >= TS_W'(TIMEOUT_CYCLES));
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        llm_lane #(
            .TS_W          (TS_W),
            .STABLE_CYCLES (STABLE_CYCLES),
            .DROP_W        (DROP_W)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .clear        (clear),
            .now          (now),
            .bit_locked   (bit_locked[i]),
            .frame_locked (frame_locked[i]),
            .prbs_meas_ok (prbs_meas_ok[i]),
            .prbs_match   (prbs_match[i]),
`ifdef LINK_LOCK_MONITOR_TIMEOUT_EN
            .timeout_hit  (timeout_hit),
            .timeout      (timeout[i]),
`endif
            .ts_bit       (ts_bit_a[i]),
            .ts_frame     (ts_frame_a[i]),
            .ts_match     (ts_match_a[i]),
            .run_cnt      (run_cnt_a[i]),
            .drop_cnt     (drop_cnt_a[i]),
            .stable       (stable[i]),
            .status       (status_a[i])
        );
        assign status[3*i +: 3] = status_a[i];
    end

    assign all_stable = &stable;

    always_comb begin
        rd_mux = '0;
        if (32'(rd_ch) < 32'(NCH)) begin
            case (rd_sel)
                RD_TS_BIT:   rd_mux = ts_bit_a[rd_ch];
                RD_TS_FRAME: rd_mux = ts_frame_a[rd_ch];
                RD_TS_MATCH: rd_mux = ts_match_a[rd_ch];
                RD_DROP_CNT: rd_mux = TS_W'(drop_cnt_a[rd_ch]);
                RD_RUN_CNT:  rd_mux = run_cnt_a[rd_ch];
                RD_STATUS:   rd_mux = TS_W'(status_a[rd_ch]);
                RD_NOW:      rd_mux = now;
                RD_ZERO:     rd_mux = '0;
                default:     rd_mux = '0;
            endcase
        end
    end

    // The strobe is registered one count early so it coincides with the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            now          <= TS_W'(1);
            rpt_cnt      <= '0;
            report_pulse <= 1'b0;
            rd_data      <= '0;
        end else begin
            now     <= TS_W'(sat_inc(32'(now), 32'({TS_W{1'b1}})));
            rd_data <= rd_mux;
            if (clear) begin
                rpt_cnt      <= '0;
                report_pulse <= 1'b0;
            end else begin
                rpt_cnt      <= (rpt_cnt == RPT_W'(REPORT_CYCLES - 1)) ? '0 : rpt_cnt + 1'b1;
                report_pulse <= (rpt_cnt == RPT_W'(REPORT_CYCLES - 2));
            end
        end
    end

endmodule

// File: tb/tb_link_lock_monitor.sv
// Random-stimulus bench for link_lock_monitor against an event-level reference model.
module tb_link_lock_monitor;
    localparam int NCH = 3;
    localparam int TS_W = 32;
    localparam int SC = 16;
    localparam int RC = 100;
    localparam int DROP_W = 4;
    localparam int TO = 500;
    localparam int NCYC = 4000;
    localparam longint DROP_MAX = (64'd1 << DROP_W) - 1;

    logic clk = 1'b0;
    logic rst, clear;
    logic [NCH-1:0] bit_locked, frame_locked, prbs_meas_ok, prbs_match;
    logic [1:0] rd_ch;
    logic [2:0] rd_sel;
    logic [TS_W-1:0] rd_data;
    logic [NCH-1:0] stable;
    logic [3*NCH-1:0] status;
    logic all_stable, report_pulse;
`ifdef LINK_LOCK_MONITOR_TIMEOUT_EN
    logic [NCH-1:0] timeout;
`endif

    link_lock_monitor #(
        .NCH(NCH), .TS_W(TS_W), .STABLE_CYCLES(SC), .REPORT_CYCLES(RC), .DROP_W(DROP_W)
`ifdef LINK_LOCK_MONITOR_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk(clk), .rst(rst), .bit_locked(bit_locked), .frame_locked(frame_locked),
        .prbs_meas_ok(prbs_meas_ok), .prbs_match(prbs_match), .clear(clear),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data), .stable(stable), .status(status),
`ifdef LINK_LOCK_MONITOR_TIMEOUT_EN
        .timeout(timeout),
`endif
        .all_stable(all_stable), .report_pulse(report_pulse)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model of what the DUT shows in the current cycle.
    longint m_now, m_rcyc, m_rd;
    longint m_tsb[NCH], m_tsf[NCH], m_tsm[NCH], m_drop[NCH], m_streak[NCH];
    bit     m_stable[NCH], m_prevm[NCH], m_to[NCH];
    int     m_status[NCH];

    function automatic void clear_lane(int l);
        m_tsb[l] = 0; m_tsf[l] = 0; m_tsm[l] = 0; m_drop[l] = 0; m_streak[l] = 0;
        m_stable[l] = 0; m_prevm[l] = 0; m_to[l] = 0; m_status[l] = 0;
    endfunction

    function automatic void reset_model();
        m_now = 1; m_rcyc = 0; m_rd = 0;
        for (int l = 0; l < NCH; l++) clear_lane(l);
    endfunction

    function automatic int code(int l);
`ifdef LINK_LOCK_MONITOR_TIMEOUT_EN
        if (m_to[l]) return 7;
`endif
        if (m_stable[l]) return 4;
        if (m_tsm[l] != 0) return 3;
        if (m_tsf[l] != 0) return 2;
        if (m_tsb[l] != 0) return 1;
        return 0;
    endfunction

    function automatic longint field(int ch, int sel);
        if (ch >= NCH) return 0;
        case (sel)
            0: return m_tsb[ch];
            1: return m_tsf[ch];
            2: return m_tsm[ch];
            3: return m_drop[ch];
            4: return (m_streak[ch] > SC) ? SC : m_streak[ch];
            5: return m_status[ch];
            6: return m_now;
            default: return 0;
        endcase
    endfunction

    function automatic void advance(bit [NCH-1:0] b, bit [NCH-1:0] f, bit [NCH-1:0] ok,
                                    bit [NCH-1:0] mt, bit clr, bit r, int ch, int sel);
        longint now_cur;
        longint rd_next;
        bit     hit;
        rd_next = field(ch, sel);
        if (r) begin
            reset_model();
            return;
        end
        now_cur = m_now;
        if (m_now < 64'hFFFF_FFFF) m_now = m_now + 1;
        m_rd = rd_next;
        m_rcyc = clr ? 0 : m_rcyc + 1;
        for (int l = 0; l < NCH; l++) begin
            if (clr) begin
                clear_lane(l);
            end else begin
                hit = ok[l] & mt[l];
                m_status[l] = code(l);
                m_to[l] = m_to[l] || (now_cur >= TO && !m_stable[l]);
                m_stable[l] = m_stable[l] || (m_streak[l] >= SC);
                if (m_prevm[l] && !hit && m_tsm[l] != 0 && m_drop[l] < DROP_MAX)
                    m_drop[l] = m_drop[l] + 1;
                if (m_tsb[l] == 0 && b[l]) m_tsb[l] = now_cur;
                if (m_tsf[l] == 0 && f[l]) m_tsf[l] = now_cur;
                if (m_tsm[l] == 0 && hit)  m_tsm[l] = now_cur;
                m_streak[l] = hit ? ((m_streak[l] >= SC) ? SC : m_streak[l] + 1) : 0;
                m_prevm[l] = hit;
            end
        end
    endfunction

    initial begin
        bit [NCH-1:0] b, f, ok, mt;
        bit clr, r;
        int ch, sel, all_exp;
        int mode[NCH];
        rst = 1'b1; clear = 1'b0;
        bit_locked = '0; frame_locked = '0; prbs_meas_ok = '0; prbs_match = '0;
        rd_ch = '0; rd_sel = '0;
        for (int l = 0; l < NCH; l++) mode[l] = 0;
        reset_model();
        repeat (2) @(posedge clk);
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            all_exp = 1;
            for (int l = 0; l < NCH; l++) begin
                check($sformatf("stable[%0d]@%0d", l, c), 64'(stable[l]), 64'(m_stable[l]));
                check($sformatf("status[%0d]@%0d", l, c), 64'(status[3*l +: 3]), 64'(m_status[l]));
`ifdef LINK_LOCK_MONITOR_TIMEOUT_EN
                check($sformatf("timeout[%0d]@%0d", l, c), 64'(timeout[l]), 64'(m_to[l]));
`endif
                if (!m_stable[l]) all_exp = 0;
            end
            check($sformatf("all_stable@%0d", c), 64'(all_stable), 64'(all_exp));
            check($sformatf("report_pulse@%0d", c), 64'(report_pulse), 64'((m_rcyc % RC) == RC - 1));
            check($sformatf("rd_data@%0d", c), 64'(rd_data), 64'(m_rd));

            b = '0; f = '0; ok = '0; mt = '0; clr = 0; r = 0;
            if (c < 60) begin
                // Lane0 locks bit at 10, frame at 20, matches from 30 onward.
                b[0] = (c >= 10); f[0] = (c >= 20); ok[0] = (c >= 30); mt[0] = (c >= 30);
                ch = 0; sel = c % 7;
            end else begin
                if (c % 64 == 0)
                    for (int l = 0; l < NCH; l++) mode[l] = $urandom_range(0, 3);
                for (int l = 0; l < NCH; l++) begin
                    b[l] = ($urandom_range(0, 9) == 0);
                    f[l] = ($urandom_range(0, 11) == 0);
                    case (mode[l])
                        0: begin ok[l] = 1; mt[l] = ($urandom_range(0, 39) != 0); end
                        1: begin ok[l] = $urandom_range(0, 1); mt[l] = $urandom_range(0, 1); end
                        2: begin ok[l] = 1; mt[l] = c[0]; end
                        default: begin ok[l] = 0; mt[l] = $urandom_range(0, 1); end
                    endcase
                end
                clr = ($urandom_range(0, 249) == 0);
                r = ($urandom_range(0, 899) == 0);
                ch = $urandom_range(0, 3);
                sel = $urandom_range(0, 7);
            end
            bit_locked = b; frame_locked = f; prbs_meas_ok = ok; prbs_match = mt;
            clear = clr; rst = r; rd_ch = 2'(ch); rd_sel = 3'(sel);
            advance(b, f, ok, mt, clr, r, ch, sel);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
